// File: rtl/icache_axi_rd_bridge_if.sv
// Bundles the cache miss port and the AXI read-address/read-data channels.
// The bridge uses the master modport; the cache/interconnect side uses slave.
interface icache_axi_rd_bridge_if #(
  parameter int A_WIDTH = 32
);
  logic [A_WIDTH-1:0] m_a;
  logic               m_strobe;
  logic [31:0]        m_dout;
  logic               m_ready;
  logic               m_err;

  logic [3:0]         arid;
  logic [A_WIDTH-1:0] araddr;
  logic [7:0]         arlen;
  logic [2:0]         arsize;
  logic [1:0]         arburst;
  logic [1:0]         arlock;
  logic [3:0]         arcache;
  logic [2:0]         arprot;
  logic               arvalid;
  logic               arready;

  logic [3:0]         rid;
  logic [31:0]        rdata;
  logic [1:0]         rresp;
  logic               rlast;
  logic               rvalid;
  logic               rready;

  modport master (
    input  m_a, m_strobe, arready, rid, rdata, rresp, rlast, rvalid,
    output m_dout, m_ready, m_err, arid, araddr, arlen, arsize, arburst,
           arlock, arcache, arprot, arvalid, rready
  );

  modport slave (
    output m_a, m_strobe, arready, rid, rdata, rresp, rlast, rvalid,
    input  m_dout, m_ready, m_err, arid, araddr, arlen, arsize, arburst,
           arlock, arcache, arprot, arvalid, rready
  );
endinterface

// File: rtl/icache_axi_rd_bridge.sv
// Turns one instruction-cache miss at a time into a single-beat AXI read and
// returns the word with a one-cycle m_ready pulse.
module icache_axi_rd_bridge #(
  parameter int         A_WIDTH = 32,
  parameter logic [3:0] AXI_ID  = 4'd0
) (
  input logic                     clk,
  input logic                     rst,
  icache_axi_rd_bridge_if.master  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]         r_state;
  logic [A_WIDTH-1:0] r_araddr;
  logic               r_arvalid;
  logic               r_rready;
  logic [31:0]        r_m_dout;
  logic               r_m_err;
  logic               r_drop;
  logic               w_drop;
  logic               w_unused;

  // A strobe falling in the beat cycle itself also discards the data.
  assign w_drop   = r_drop | ~bus.m_strobe;
  assign w_unused = ^{bus.rid, bus.rlast, bus.m_a[1:0]};

  // Miss sequencer: IDLE -> ADDR -> DATA -> DONE, with sticky abort tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_araddr  <= {A_WIDTH{1'b0}};
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_m_dout  <= 32'd0;
      r_m_err   <= 1'b0;
      r_drop    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.m_strobe) begin
            r_araddr  <= {bus.m_a[A_WIDTH-1:2], 2'b00};
            r_arvalid <= 1'b1;
            r_drop    <= 1'b0;
            r_state   <= S_ADDR;
          end
        end
        S_ADDR: begin
          r_drop <= w_drop;
          if (bus.arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_DATA;
          end
        end
        S_DATA: begin
          r_drop <= w_drop;
          if (bus.rvalid) begin
            r_m_dout <= bus.rdata;
            r_m_err  <= (bus.rresp != 2'b00);
            r_rready <= 1'b0;
            r_state  <= w_drop ? S_IDLE : S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state   <= S_IDLE;
          r_arvalid <= 1'b0;
          r_rready  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.m_dout  = r_m_dout;
  assign bus.m_ready = (r_state == S_DONE);
  assign bus.m_err   = (r_state == S_DONE) & r_m_err;

  assign bus.arid    = AXI_ID;
  assign bus.araddr  = r_araddr;
  assign bus.arlen   = 8'd0;
  assign bus.arsize  = 3'b010;
  assign bus.arburst = 2'b01;
  assign bus.arlock  = 2'b00;
  assign bus.arcache = 4'b0000;
  assign bus.arprot  = 3'b000;
  assign bus.arvalid = r_arvalid;
  assign bus.rready  = r_rready;

endmodule

// File: tb/tb_icache_axi_rd_bridge.sv
// Directed scoreboard bench: tasks push expected AR addresses and responses,
// a negedge monitor pops and compares whenever the bridge presents them.
module tb_icache_axi_rd_bridge;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  int   ar_seen;
  int   ar_expected;

  logic [31:0] ar_q[$];
  logic [32:0] r_q[$];

  logic        mon_prev_wait;
  logic [31:0] mon_prev_addr;

  icache_axi_rd_bridge_if #(.A_WIDTH(32)) bus ();

  icache_axi_rd_bridge #(.A_WIDTH(32), .AXI_ID(4'd0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: AR handshakes and m_ready pulses are checked against the queues.
  always @(negedge clk) begin
    if (rst) begin
      mon_prev_wait = 1'b0;
    end else begin
      if (mon_prev_wait && bus.arvalid)
        chk("araddr_stable", {32'd0, bus.araddr}, {32'd0, mon_prev_addr});
      if (bus.arvalid && bus.arready) begin
        ar_seen++;
        if (ar_q.size() == 0) begin
          chk("unexpected_ar", 64'd1, 64'd0);
        end else begin
          chk("araddr", {32'd0, bus.araddr}, {32'd0, ar_q.pop_front()});
        end
        chk("arlen",   {56'd0, bus.arlen},   64'd0);
        chk("arsize",  {61'd0, bus.arsize},  64'd2);
        chk("arburst", {62'd0, bus.arburst}, 64'd1);
        chk("arid",    {60'd0, bus.arid},    64'd0);
      end
      if (bus.m_ready) begin
        if (r_q.size() == 0) begin
          chk("unexpected_m_ready", 64'd1, 64'd0);
        end else begin
          chk("m_dout_m_err", {31'd0, bus.m_dout, bus.m_err}, {31'd0, r_q.pop_front()});
        end
      end
      mon_prev_wait = bus.arvalid && !bus.arready;
      mon_prev_addr = bus.araddr;
    end
  end

  task automatic wait_arvalid(input string name);
    int n;
    n = 0;
    while (!bus.arvalid && n < 10) begin
      tick();
      n++;
    end
    chk(name, {63'd0, bus.arvalid}, 64'd1);
  endtask

  task automatic run_miss(input logic [31:0] a, input logic [31:0] exp_addr,
                          input int ar_wait, input int r_wait,
                          input logic [31:0] d, input logic [1:0] resp,
                          input bit abort, input int abort_cyc);
    ar_q.push_back(exp_addr);
    ar_expected++;
    if (!abort) r_q.push_back({d, resp != 2'b00});
    bus.m_a      = a;
    bus.m_strobe = 1'b1;
    bus.arready  = 1'b0;
    bus.rvalid   = 1'b0;
    tick();
    wait_arvalid("arvalid_next_cycle");
    for (int i = 0; i < ar_wait; i++) tick();
    bus.arready = 1'b1;
    tick();
    bus.arready = 1'b0;
    for (int i = 0; i < r_wait; i++) begin
      chk("rready_wait", {63'd0, bus.rready}, 64'd1);
      if (abort && i == abort_cyc) bus.m_strobe = 1'b0;
      tick();
    end
    chk("rready_beat", {63'd0, bus.rready}, 64'd1);
    bus.rvalid = 1'b1;
    bus.rdata  = d;
    bus.rresp  = resp;
    tick();
    bus.rvalid = 1'b0;
    chk("rready_after", {63'd0, bus.rready}, 64'd0);
    chk("m_ready_now", {63'd0, bus.m_ready}, {63'd0, !abort});
    bus.m_strobe = 1'b0;
    tick();
    chk("m_ready_gone", {63'd0, bus.m_ready}, 64'd0);
    chk("m_err_gone", {63'd0, bus.m_err}, 64'd0);
    chk("idle_arvalid", {63'd0, bus.arvalid}, 64'd0);
  endtask

  initial begin
    tests = 0; fails = 0; ar_seen = 0; ar_expected = 0;
    mon_prev_wait = 1'b0; mon_prev_addr = 32'd0;
    rst = 1'b1;
    bus.m_a = 32'd0; bus.m_strobe = 1'b0;
    bus.arready = 1'b0; bus.rid = 4'd0; bus.rdata = 32'd0;
    bus.rresp = 2'b00; bus.rlast = 1'b1; bus.rvalid = 1'b0;
    tick();
    tick();
    chk("rst_arvalid", {63'd0, bus.arvalid}, 64'd0);
    chk("rst_rready",  {63'd0, bus.rready},  64'd0);
    chk("rst_m_ready", {63'd0, bus.m_ready}, 64'd0);
    chk("rst_m_err",   {63'd0, bus.m_err},   64'd0);
    chk("rst_araddr",  {32'd0, bus.araddr},  64'd0);
    chk("rst_m_dout",  {32'd0, bus.m_dout},  64'd0);
    rst = 1'b0;
    tick();

    // rvalid while idle must not be accepted
    bus.rvalid = 1'b1;
    bus.rdata  = 32'h12345678;
    #1;
    chk("idle_rready", {63'd0, bus.rready}, 64'd0);
    tick();
    bus.rvalid = 1'b0;
    chk("idle_no_m_ready", {63'd0, bus.m_ready}, 64'd0);

    run_miss(32'hBFC00104, 32'hBFC00104, 0, 0, 32'h3C1D0010, 2'b00, 1'b0, 0);
    run_miss(32'h20000040, 32'h20000040, 5, 7, 32'hA5A55A5A, 2'b00, 1'b0, 0);
    run_miss(32'h00001007, 32'h00001004, 0, 1, 32'h0BADF00D, 2'b00, 1'b0, 0);
    run_miss(32'h00002000, 32'h00002000, 1, 4, 32'hDEADBEEF, 2'b00, 1'b1, 1);
    run_miss(32'h00000080, 32'h00000080, 0, 0, 32'h00000080, 2'b00, 1'b0, 0);
    run_miss(32'h40000008, 32'h40000008, 2, 2, 32'hCAFEBABE, 2'b10, 1'b0, 0);

    // Reset while in ADDR, strobe held throughout
    bus.m_a      = 32'h00000100;
    bus.m_strobe = 1'b1;
    bus.arready  = 1'b0;
    tick();
    wait_arvalid("rst_case_arvalid");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_arvalid", {63'd0, bus.arvalid}, 64'd0);
    chk("midrst_rready",  {63'd0, bus.rready},  64'd0);
    chk("midrst_m_ready", {63'd0, bus.m_ready}, 64'd0);
    tick();
    chk("post_rst_ar", {63'd0, bus.arvalid}, 64'd1);
    ar_q.push_back(32'h00000100);
    ar_expected++;
    r_q.push_back({32'h11223344, 1'b0});
    bus.arready = 1'b1;
    tick();
    bus.arready = 1'b0;
    bus.rvalid  = 1'b1;
    bus.rdata   = 32'h11223344;
    bus.rresp   = 2'b00;
    tick();
    bus.rvalid = 1'b0;
    chk("post_rst_m_ready", {63'd0, bus.m_ready}, 64'd1);
    bus.m_strobe = 1'b0;
    tick();
    tick();

    chk("ar_count", 64'(ar_seen), 64'(ar_expected));
    chk("ar_q_empty", 64'(ar_q.size()), 64'd0);
    chk("r_q_empty", 64'(r_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
